// File: rtl/fetch_unit.sv
// Instruction-fetch / PC stage: req/ready fetch, one-window EXEC, next-PC select, timeout and misalignment halt.
// Optional FETCH_PERF_CNT_EN adds instret and fetch_wait_cycles counters.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16,
    parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ireq,
    output logic [31:0] iaddr,
    input  logic        iready,
    input  logic [31:0] idata_in,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    input  logic        jump,
    input  logic        jalr,
    input  logic        branch,
    input  logic        br_taken,
    input  logic [31:0] imm,
    input  logic [31:0] rs1_val,
    input  logic        stall,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] instret,
    output logic [31:0] fetch_wait_cycles,
`endif
    output logic        halted,
    output logic [1:0]  err_code
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_FETCH, S_WAIT, S_EXEC, S_HALT} state_t;

    state_t          state_reg;
    logic [31:0]     pc_reg;
    logic [31:0]     instr_reg;
    logic            instr_valid_reg;
    logic            halted_reg;
    logic [1:0]      err_code_reg;
    logic [CW-1:0]   count_reg;
    logic [31:0]     next_pc;
    logic [31:0]     jalr_sum;

    assign jalr_sum = rs1_val + imm;

    always_comb begin
        next_pc = pc_reg + 32'd4;
        if (jump && jalr)
            next_pc = jalr_sum & ~32'h1;
        else if (jump)
            next_pc = pc_reg + imm;
        else if (branch && br_taken)
            next_pc = pc_reg + imm;
    end

    // Request is dropped while reset is held so nothing is issued before release.
    assign ireq        = reset && ((state_reg == S_FETCH) || (state_reg == S_WAIT));
    assign iaddr       = pc_reg;
    assign pc          = pc_reg;
    assign instr       = instr_reg;
    assign instr_valid = instr_valid_reg;
    assign halted      = halted_reg;
    assign err_code    = err_code_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg       <= S_FETCH;
            pc_reg          <= RESET_PC;
            instr_reg       <= NOP_WORD;
            instr_valid_reg <= 1'b0;
            halted_reg      <= 1'b0;
            err_code_reg    <= 2'b00;
            count_reg       <= '0;
        end else begin
            case (state_reg)
                S_FETCH: begin
                    if (iready) begin
                        instr_reg       <= idata_in;
                        instr_valid_reg <= 1'b1;
                        state_reg       <= S_EXEC;
                    end else begin
                        count_reg <= CW'(1);
                        state_reg <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // iready on the final allowed cycle still wins over the timeout.
                    if (iready) begin
                        instr_reg       <= idata_in;
                        instr_valid_reg <= 1'b1;
                        count_reg       <= '0;
                        state_reg       <= S_EXEC;
                    end else if (count_reg == CW'(TIMEOUT - 1)) begin
                        count_reg    <= CW'(TIMEOUT);
                        halted_reg   <= 1'b1;
                        err_code_reg <= 2'b01;
                        state_reg    <= S_HALT;
                    end else begin
                        count_reg <= count_reg + CW'(1);
                    end
                end
                S_EXEC: begin
                    if (!stall) begin
                        instr_reg       <= NOP_WORD;
                        instr_valid_reg <= 1'b0;
                        if (next_pc[1:0] != 2'b00) begin
                            halted_reg   <= 1'b1;
                            err_code_reg <= 2'b10;
                            state_reg    <= S_HALT;
                        end else begin
                            pc_reg    <= next_pc;
                            state_reg <= S_FETCH;
                        end
                    end
                end
                default: begin
                    instr_reg       <= NOP_WORD;
                    instr_valid_reg <= 1'b0;
                    halted_reg      <= 1'b1;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] instret_reg;
    logic [31:0] fetch_wait_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            instret_reg    <= '0;
            fetch_wait_reg <= '0;
        end else begin
            if (state_reg == S_EXEC && !stall && next_pc[1:0] == 2'b00)
                instret_reg <= instret_reg + 32'd1;
            if (state_reg == S_WAIT)
                fetch_wait_reg <= fetch_wait_reg + 32'd1;
        end
    end

    assign instret           = instret_reg;
    assign fetch_wait_cycles = fetch_wait_reg;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: table of single-instruction vectors plus hand sequences for stall, misalign, timeout and reset.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        ireq;
    logic [31:0] iaddr;
    logic        iready;
    logic [31:0] idata_in;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic        jump, jalr, branch, br_taken;
    logic [31:0] imm, rs1_val;
    logic        stall;
    logic        halted;
    logic [1:0]  err_code;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] instret;
    logic [31:0] fetch_wait_cycles;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .reset(reset), .ireq(ireq), .iaddr(iaddr), .iready(iready),
        .idata_in(idata_in), .instr(instr), .instr_valid(instr_valid), .pc(pc),
        .jump(jump), .jalr(jalr), .branch(branch), .br_taken(br_taken),
        .imm(imm), .rs1_val(rs1_val), .stall(stall),
`ifdef FETCH_PERF_CNT_EN
        .instret(instret), .fetch_wait_cycles(fetch_wait_cycles),
`endif
        .halted(halted), .err_code(err_code)
    );

    typedef struct {
        logic [31:0] word;
        logic        jump, jalr, branch, br_taken;
        logic [31:0] imm, rs1;
        logic [31:0] exp_next;
    } vec_t;

    vec_t vecs [10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end else begin
            $display("ok   %s: %08h", name, act);
        end
    endtask

    task automatic clear_ctrl();
        jump = 0; jalr = 0; branch = 0; br_taken = 0; imm = 0; rs1_val = 0; stall = 0;
    endtask

    task automatic do_reset();
        reset = 0;
        tick();
        tick();
        reset = 1;
    endtask

    // From FETCH: deliver one word immediately and land in EXEC.
    task automatic fetch_now(input logic [31:0] word);
        iready = 1; idata_in = word;
        tick();
        iready = 0;
    endtask

    task automatic exec_ctrl(input logic j, input logic jr, input logic b, input logic bt,
                             input logic [31:0] im, input logic [31:0] r1);
        jump = j; jalr = jr; branch = b; br_taken = bt; imm = im; rs1_val = r1;
        tick();
        clear_ctrl();
    endtask

    initial begin
        logic [31:0] cur_pc;

        vecs[0] = '{32'h00500093, 0, 0, 0, 0, 32'h0,        32'h0,        32'h4};
        vecs[1] = '{32'h00500093, 0, 0, 0, 0, 32'h0,        32'h0,        32'h8};
        vecs[2] = '{32'h00100113, 1, 0, 0, 0, 32'hF8,       32'h0,        32'h100};
        vecs[3] = '{32'h00200193, 1, 0, 0, 0, 32'hFFFF_FFF0, 32'h0,       32'hF0};
        vecs[4] = '{32'h00300213, 0, 0, 1, 1, 32'h10,       32'h0,        32'h100};
        vecs[5] = '{32'h00400293, 0, 0, 1, 0, 32'h40,       32'h0,        32'h104};
        vecs[6] = '{32'h00500313, 1, 1, 0, 0, 32'h0,        32'h205,      32'h204};
        vecs[7] = '{32'h00600393, 1, 1, 1, 1, 32'h10,       32'h300,      32'h310};
        vecs[8] = '{32'h00700413, 1, 1, 0, 0, 32'h0,        32'hFFFF_FFFC, 32'hFFFF_FFFC};
        vecs[9] = '{32'h00800493, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0};

        iready = 0; idata_in = 0; clear_ctrl();
        reset = 0;
        tick();
        tick();
        check("rst_ireq", 32'(ireq), 32'h0);
        check("rst_pc", pc, 32'h0);
        check("rst_instr", instr, NOP);
        check("rst_valid", 32'(instr_valid), 32'h0);
        check("rst_halted", 32'(halted), 32'h0);
        check("rst_err", 32'(err_code), 32'h0);
        reset = 1;
        #1;
        check("fetch0_ireq", 32'(ireq), 32'h1);
        check("fetch0_iaddr", iaddr, 32'h0);

        cur_pc = 32'h0;
        for (int i = 0; i < 10; i++) begin
            fetch_now(vecs[i].word);
            check($sformatf("v%0d_valid", i), 32'(instr_valid), 32'h1);
            check($sformatf("v%0d_instr", i), instr, vecs[i].word);
            check($sformatf("v%0d_pc", i), pc, cur_pc);
            check($sformatf("v%0d_ireq_exec", i), 32'(ireq), 32'h0);
            exec_ctrl(vecs[i].jump, vecs[i].jalr, vecs[i].branch, vecs[i].br_taken,
                      vecs[i].imm, vecs[i].rs1);
            check($sformatf("v%0d_iaddr", i), iaddr, vecs[i].exp_next);
            check($sformatf("v%0d_ireq", i), 32'(ireq), 32'h1);
            check($sformatf("v%0d_instr_nop", i), instr, NOP);
            cur_pc = vecs[i].exp_next;
        end

        // Stall holds EXEC for three cycles, then the jalr commits.
        fetch_now(32'h12345678);
        jump = 1; jalr = 1; rs1_val = 32'h205; imm = 32'h0; stall = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("stall%0d_pc", k), pc, 32'h0);
            check($sformatf("stall%0d_instr", k), instr, 32'h12345678);
            check($sformatf("stall%0d_valid", k), 32'(instr_valid), 32'h1);
        end
        stall = 0;
        tick();
        clear_ctrl();
        check("stall_commit_iaddr", iaddr, 32'h204);
        check("stall_commit_ireq", 32'(ireq), 32'h1);

        // Reach pc=0x40, then a taken branch to a misaligned target.
        fetch_now(32'h1);
        exec_ctrl(1, 1, 0, 0, 32'h0, 32'h40);
        check("mis_setup_iaddr", iaddr, 32'h40);
        fetch_now(32'h2);
        exec_ctrl(0, 0, 1, 1, 32'h2, 32'h0);
        check("mis_halted", 32'(halted), 32'h1);
        check("mis_err", 32'(err_code), 32'h2);
        check("mis_pc", pc, 32'h40);
        check("mis_ireq", 32'(ireq), 32'h0);
        check("mis_valid", 32'(instr_valid), 32'h0);
        iready = 1;
        tick(); tick(); tick();
        iready = 0;
        check("mis_sticky_halted", 32'(halted), 32'h1);
        check("mis_sticky_ireq", 32'(ireq), 32'h0);
        check("mis_sticky_instr", instr, NOP);

        // Timeout: ireq high for 16 cycles, halt afterwards.
        do_reset();
        #1;
        for (int c = 1; c <= 16; c++) begin
            check($sformatf("to_c%0d_ireq", c), 32'(ireq), 32'h1);
            tick();
        end
        check("to_halted", 32'(halted), 32'h1);
        check("to_err", 32'(err_code), 32'h1);
        check("to_ireq", 32'(ireq), 32'h0);
        check("to_pc", pc, 32'h0);

        // iready on exactly the 16th cycle wins over the timeout.
        do_reset();
        #1;
        for (int c = 1; c <= 15; c++) tick();
        check("late_ireq", 32'(ireq), 32'h1);
        iready = 1; idata_in = 32'hCAFE0013;
        tick();
        iready = 0;
        check("late_valid", 32'(instr_valid), 32'h1);
        check("late_instr", instr, 32'hCAFE0013);
        check("late_halted", 32'(halted), 32'h0);
        check("late_err", 32'(err_code), 32'h0);

        // Commit, enter WAIT, then reset mid-handshake with a coincident iready.
        exec_ctrl(0, 0, 0, 0, 32'h0, 32'h0);
        check("late_next_iaddr", iaddr, 32'h4);
        tick();
        tick();
        check("wait_ireq", 32'(ireq), 32'h1);
        reset = 0; iready = 1; idata_in = 32'hDEAD0013;
        tick();
        iready = 0;
        check("midrst_pc", pc, 32'h0);
        check("midrst_ireq", 32'(ireq), 32'h0);
        check("midrst_valid", 32'(instr_valid), 32'h0);
        check("midrst_instr", instr, NOP);
        reset = 1;
        #1;
        check("midrst_fetch_ireq", 32'(ireq), 32'h1);
        check("midrst_fetch_iaddr", iaddr, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
